// File: rtl/bus_serial_pkg.sv
// Shared types and constants for the byte-serial CPU bus target side.
package bus_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CMD  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam logic        CMD_WRITE   = 1'b1;
    localparam int unsigned FRAME_BEATS = 9;
    localparam int unsigned ADDR_BEATS  = 4;
    localparam int unsigned DATA_BEATS  = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BEAT_W      = 2;

    // Address and data phases both span four beats, so one terminal count serves both.
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ADDR_BEATS - 1);

endpackage

// File: rtl/bus_word_ram.sv
// Word RAM for the bus responder: synchronous write, combinational read,
// whole array cleared while reset is held.
module bus_word_ram
    import bus_serial_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_mem_responder.sv
// Target end of the byte-serial CPU bus: decodes 9-beat frames and serves
// them from a local word RAM, driving read data back on the shared data pins.
module bus_mem_responder
    import bus_serial_pkg::*;
#(
    parameter int unsigned  DEPTH     = 16,
    parameter logic [31:0]  BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0]  BAD_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync,
    input  logic [7:0]  addr_byte,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [7:0]  data_oe,
    output logic        txn_done,
    output logic        bad_addr
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam logic [WORD_W-1:0] WIN_BYTES = WORD_W'(DEPTH * 4);

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [WORD_W-1:0]   r_addr;
    logic [23:0]         r_rx;
    logic [23:0]         r_tx;
    logic                r_write;
    logic                r_in_win;
    logic [IDX_W-1:0]    r_idx;

    logic [WORD_W-1:0]   w_off;
    logic                w_in_win;
    logic [IDX_W-1:0]    w_idx;
    logic [WORD_W-1:0]   w_rd_word;
    logic [WORD_W-1:0]   w_tx_word;
    logic [WORD_W-1:0]   w_wr_word;
    logic                w_commit;

    // Window decode; subtraction wraps so windows near the top of the map still work.
    assign w_off     = r_addr - BASE_ADDR;
    assign w_in_win  = (w_off < WIN_BYTES);
    assign w_idx     = w_off[IDX_W+1:2];
    assign w_tx_word = w_in_win ? w_rd_word : BAD_DATA;

    // Final data byte joins the three already shifted in.
    assign w_wr_word = {data_in, r_rx};
    assign w_commit  = !sync && (r_state == DATA) && (r_beat == LAST_BEAT)
                       && r_write && r_in_win;

    bus_word_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_commit),
        .i_waddr (r_idx),
        .i_wdata (w_wr_word),
        .i_raddr (w_idx),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_addr   <= '0;
            r_rx     <= '0;
            r_tx     <= '0;
            r_write  <= 1'b0;
            r_in_win <= 1'b0;
            r_idx    <= '0;
            data_out <= 8'h00;
            data_oe  <= 8'h00;
            txn_done <= 1'b0;
            bad_addr <= 1'b0;
        end else begin
            txn_done <= 1'b0;
            if (sync) begin
                // Start of a frame; anything in flight is dropped.
                r_state  <= ADDR;
                r_beat   <= BEAT_W'(1);
                r_addr   <= {addr_byte, r_addr[31:8]};
                data_out <= 8'h00;
                data_oe  <= 8'h00;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_beat <= '0;
                    end
                    ADDR: begin
                        r_addr <= {addr_byte, r_addr[31:8]};
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= CMD;
                        end
                    end
                    CMD: begin
                        r_write  <= (addr_byte[0] == CMD_WRITE);
                        r_in_win <= w_in_win;
                        r_idx    <= w_idx;
                        r_beat   <= '0;
                        r_state  <= DATA;
                        if (!w_in_win) begin
                            bad_addr <= 1'b1;
                        end
                        if (addr_byte[0] != CMD_WRITE) begin
                            r_tx     <= w_tx_word[31:8];
                            data_out <= w_tx_word[7:0];
                            data_oe  <= 8'hFF;
                        end
                    end
                    DATA: begin
                        r_rx   <= {data_in, r_rx[23:8]};
                        r_beat <= r_beat + BEAT_W'(1);
                        if (!r_write) begin
                            r_tx     <= {8'h00, r_tx[23:8]};
                            data_out <= r_tx[7:0];
                        end
                        if (r_beat == LAST_BEAT) begin
                            data_out <= 8'h00;
                            data_oe  <= 8'h00;
                            txn_done <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
